ub_activation_feeder: RTL and testbench
=======================================

UB_ACTIVATION_FEEDER -- requirements
Module: ub_activation_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 32, lane count of the unified buffer row and MXU input edge.
REQ-002 SHALL have parameter DATA_W, default 16, bits per lane element.
REQ-003 SHALL have parameter ADDR_W, default 12, unified buffer row-address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports clk_i and rst_i.
REQ-005 clk_i  input  1  rising-edge clock for all state.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 start_i  input  1  request a transfer; sampled only in IDLE.
REQ-008 base_addr_i  input  ADDR_W  first unified buffer row; captured with start_i.
REQ-009 num_rows_i  input  ADDR_W  row count N; captured with start_i.
REQ-010 ub_rd_en_o  output  1  read strobe to the unified buffer.
REQ-011 ub_rd_addr_o  output  ADDR_W  read address to the unified buffer.
REQ-012 ub_data_i  input  ROWS x DATA_W  unified buffer read data, valid one cycle after ub_rd_en_o.
REQ-013 mxu_data_o  output  ROWS x DATA_W  skewed activations to the matrix unit.
REQ-014 mxu_valid_o  output  ROWS  per-lane valid.
REQ-015 busy_o  output  1  transfer in progress.
REQ-016 done_o  output  1  single-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN; IDLE->READ on start_i with N>0; READ->DRAIN after N reads; DRAIN->IDLE after ROWS+1 cycles.
REQ-018 With start_i sampled high in cycle 0 and N>0, ub_rd_en_o SHALL be 1 in cycles 1..N with ub_rd_addr_o = (base + i - 1) mod 2^ADDR_W in cycle i.
REQ-019 Address arithmetic SHALL wrap modulo 2^ADDR_W; no error on wrap.
REQ-020 ub_rd_en_o SHALL be 0 and ub_rd_addr_o SHALL hold its last value outside READ.
REQ-021 Lane k SHALL present ub_data_i[k] delayed by k+1 registered stages; row j (0-based) appears on lane k in cycle 3+j+k with mxu_valid_o[k]=1.
REQ-022 busy_o SHALL be 1 in cycles 1..N+ROWS+1; done_o SHALL be 1 only in cycle N+ROWS+2.
REQ-023 N=0 SHALL issue no reads, keep busy_o 0, and pulse done_o in cycle 1.
REQ-024 start_i while busy_o=1 SHALL be ignored; start_i in the done_o cycle SHALL be accepted.
REQ-025 Base and count SHALL be latched at start; input changes during a transfer SHALL have no effect.

Reset
REQ-026 On rst_i: state IDLE; ub_rd_en_o, ub_rd_addr_o, mxu_data_o, mxu_valid_o, busy_o, done_o all 0; all skew stages cleared.
REQ-027 Reset mid-transfer SHALL abort it immediately without a done_o pulse; the next start_i SHALL run normally.

Configuration
REQ-028 Macro FEEDER_ZERO_PAD_EN defined: mxu_data_o[k] SHALL be forced to 0 whenever mxu_valid_o[k]=0.
REQ-029 Macro FEEDER_ZERO_PAD_EN undefined: mxu_data_o[k] SHALL be the raw skew-stage contents regardless of valid; valid timing is unchanged.

Structure
REQ-030 ROWS, DATA_W, and UB_ADDR_W defaults plus typedef feeder_state_t SHALL live in shared package tpu_pkg.
REQ-031 Per-lane delay SHALL be one sub-module, skew_delay_line, parameterised by depth and carrying data and valid.

Verification
REQ-032 Reset, then idle for 10 cycles -> all outputs 0, no reads issued.
REQ-033 Start with base=0x010 and N=4, with ub row r filled with value r+lane -> reads 0x010..0x013 in cycles 1..4; lane 5 is valid in cycles 8..11 carrying 0x10+5..0x13+5; done_o is high in cycle 38.
REQ-034 Start with base=0xFFE and N=3 -> addresses 0xFFE, 0xFFF, 0x000.
REQ-035 Start with N=0 -> no ub_rd_en_o, busy_o never high, done_o in cycle 1; a start_i pulse while busy is ignored.
REQ-036 rst_i in cycle 3 of an N=8 transfer -> outputs 0 next cycle, no done_o; a fresh N=1 start completes with done_o in cycle 35.
REQ-037 Run with and without FEEDER_ZERO_PAD_EN -> invalid lanes read 0 only when the macro is defined.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the unified-buffer activation feeder:
// default geometry and the feeder sequencing state type.
package tpu_pkg;

    localparam int TPU_ROWS   = 32;
    localparam int TPU_DATA_W = 16;
    localparam int UB_ADDR_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane skew stage: DEPTH registered stages carrying a data word and
// its valid flag side by side, so both arrive at the MXU edge together.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    // Shift data and valid one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/ub_activation_feeder.sv
// Unified-buffer activation feeder: reads N consecutive UB rows starting at
// a latched base address and presents them to the matrix unit with a
// diagonal skew (lane k delayed by k+1 stages).
// Build option: define FEEDER_ZERO_PAD_EN to force lane data to zero
// whenever that lane's valid is low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; N=0 requests complete immediately
// ST_READ  | issuing one UB read per cycle, N reads in total
// ST_DRAIN | reads done, ROWS+1 cycles for the skew pipeline to empty
module ub_activation_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS   = TPU_ROWS,
    parameter int DATA_W = TPU_DATA_W,
    parameter int ADDR_W = UB_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic [ADDR_W-1:0]          num_rows_i,
    output logic                       ub_rd_en_o,
    output logic [ADDR_W-1:0]          ub_rd_addr_o,
    input  logic [ROWS-1:0][DATA_W-1:0] ub_data_i,
    output logic [ROWS-1:0][DATA_W-1:0] mxu_data_o,
    output logic [ROWS-1:0]            mxu_valid_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int                 DRAIN_W    = $clog2(ROWS + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROWS);

    feeder_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  rd_left_q, rd_left_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               rd_en_q, rd_en_d;
    logic               done_q, done_d;
    logic               ub_vld_q;

    logic [ROWS-1:0][DATA_W-1:0] lane_data;

    // Next-state and next-output decode; rd_left counts remaining reads
    // down to zero, drain counts the pipeline flush down to zero.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_left_d = rd_left_q;
        drain_d   = drain_q;
        rd_en_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_rows_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr_i;
                        rd_left_d = num_rows_i - ADDR_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (rd_left_q == '0) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LAST;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; ub_vld_q marks cycles where ub_data_i
    // carries a row (one cycle after the read strobe).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            rd_left_q <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            ub_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_left_q <= rd_left_d;
            drain_q   <= drain_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
            ub_vld_q  <= rd_en_q;
        end
    end

    assign ub_rd_en_o   = rd_en_q;
    assign ub_rd_addr_o = rd_addr_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;

    for (genvar k = 0; k < ROWS; k++) begin : g_lane
        skew_delay_line #(
            .DEPTH  (k + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .data_i  (ub_data_i[k]),
            .valid_i (ub_vld_q),
            .data_o  (lane_data[k]),
            .valid_o (mxu_valid_o[k])
        );
`ifdef FEEDER_ZERO_PAD_EN
        assign mxu_data_o[k] = mxu_valid_o[k] ? lane_data[k] : '0;
`else
        assign mxu_data_o[k] = lane_data[k];
`endif
    end

endmodule

// File: tb/tb_ub_activation_feeder.sv
// Bench for ub_activation_feeder: a UB row model (row r, lane k holds r+k),
// a scoreboard of expected reads / lane outputs / busy / done cycles filled
// when each start is driven, and a negedge monitor that consumes it.
`timescale 1ns/1ps
module tb_ub_activation_feeder;

    localparam int ROWS   = 32;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic                        start_i = 1'b0;
    logic [ADDR_W-1:0]           base_addr_i = '0;
    logic [ADDR_W-1:0]           num_rows_i = '0;
    logic                        ub_rd_en_o;
    logic [ADDR_W-1:0]           ub_rd_addr_o;
    logic [ROWS-1:0][DATA_W-1:0] ub_data_i = '0;
    logic [ROWS-1:0][DATA_W-1:0] mxu_data_o;
    logic [ROWS-1:0]             mxu_valid_o;
    logic                        busy_o;
    logic                        done_o;

    ub_activation_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_rows_i   (num_rows_i),
        .ub_rd_en_o   (ub_rd_en_o),
        .ub_rd_addr_o (ub_rd_addr_o),
        .ub_data_i    (ub_data_i),
        .mxu_data_o   (mxu_data_o),
        .mxu_valid_o  (mxu_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] row_val(input logic [ADDR_W-1:0] a, input int k);
        return DATA_W'(int'(a) + k);
    endfunction

    // UB model: data for the strobed address appears the following cycle.
    always @(posedge clk_i) begin
        if (ub_rd_en_o === 1'b1)
            for (int k = 0; k < ROWS; k++) ub_data_i[k] <= row_val(ub_rd_addr_o, k);
    end

    typedef struct { int cyc; logic [ADDR_W-1:0] addr; } rd_exp_t;
    typedef struct { int cyc; int lane; logic [DATA_W-1:0] data; } lane_exp_t;

    rd_exp_t   rd_q[$];
    lane_exp_t lane_q[$];
    bit        busy_map[int];
    bit        done_map[int];
    int        checks = 0;
    int        errors = 0;
    bit        mon_en = 1'b0;

    rd_exp_t   mon_rd;
    lane_exp_t mon_ln;
    logic      mon_exp_busy, mon_exp_done;

    // Monitor: every cycle compare busy/done against the expected windows
    // and match each read strobe and each valid lane against the scoreboard.
    always @(negedge clk_i) begin
        if (mon_en) begin
            mon_exp_busy = busy_map.exists(cyc) ? 1'b1 : 1'b0;
            mon_exp_done = done_map.exists(cyc) ? 1'b1 : 1'b0;
            checks++;
            if (busy_o !== mon_exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, mon_exp_busy);
            end
            checks++;
            if (done_o !== mon_exp_done) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, mon_exp_done);
            end
            if (ub_rd_en_o !== 1'b0) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected cyc=%0d got_en=%b addr=%h exp no read", cyc, ub_rd_en_o, ub_rd_addr_o);
                end else begin
                    mon_rd = rd_q.pop_front();
                    if (mon_rd.cyc != cyc || ub_rd_addr_o !== mon_rd.addr) begin
                        errors++;
                        $display("FAIL rd_addr got cyc=%0d addr=%h exp cyc=%0d addr=%h", cyc, ub_rd_addr_o, mon_rd.cyc, mon_rd.addr);
                    end
                end
            end
            for (int k = 0; k < ROWS; k++) begin
                if (mxu_valid_o[k] !== 1'b0) begin
                    checks++;
                    if (lane_q.size() == 0) begin
                        errors++;
                        $display("FAIL lane_unexpected cyc=%0d lane=%0d got valid data=%h exp invalid", cyc, k, mxu_data_o[k]);
                    end else begin
                        mon_ln = lane_q.pop_front();
                        if (mon_ln.cyc != cyc || mon_ln.lane != k || mxu_data_o[k] !== mon_ln.data) begin
                            errors++;
                            $display("FAIL lane got cyc=%0d lane=%0d data=%h exp cyc=%0d lane=%0d data=%h",
                                     cyc, k, mxu_data_o[k], mon_ln.cyc, mon_ln.lane, mon_ln.data);
                        end
                    end
                end
            end
        end
    end

    // Drive a one-cycle start at the current negedge (cycle s) and record
    // every consequence in the scoreboard; returns at the negedge of s+1.
    task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, output int s);
        rd_exp_t   r;
        lane_exp_t l;
        int        nn;
        int        j;
        nn = int'(n);
        start_i     = 1'b1;
        base_addr_i = b;
        num_rows_i  = n;
        s = cyc;
        if (nn > 0) begin
            for (int i = 1; i <= nn; i++) begin
                r.cyc  = s + i;
                r.addr = b + ADDR_W'(i - 1);
                rd_q.push_back(r);
            end
            for (int c = s + 1; c <= s + nn + ROWS + 1; c++) busy_map[c] = 1'b1;
            done_map[s + nn + ROWS + 2] = 1'b1;
            for (int c = s + 3; c <= s + nn + ROWS + 1; c++) begin
                for (int k = 0; k < ROWS; k++) begin
                    j = c - s - 3 - k;
                    if (j >= 0 && j < nn) begin
                        l.cyc  = c;
                        l.lane = k;
                        l.data = row_val(b + ADDR_W'(j), k);
                        lane_q.push_back(l);
                    end
                end
            end
        end else begin
            done_map[s + 1] = 1'b1;
        end
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic finish_check(input string name);
        checks++;
        if (rd_q.size() != 0 || lane_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got rd=%0d lane=%0d exp 0 0", name, rd_q.size(), lane_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        mon_en = 1'b1;
        rst_i  = 1'b0;
        repeat (10) @(negedge clk_i);
        checks++;
        if (ub_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", ub_rd_en_o); end
        checks++;
        if (ub_rd_addr_o !== '0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", ub_rd_addr_o); end
        checks++;
        if (mxu_valid_o !== '0) begin errors++; $display("FAIL reset_valid got=%h exp=0", mxu_valid_o); end
        checks++;
        if (mxu_data_o !== '0) begin errors++; $display("FAIL reset_data got nonzero exp=0"); end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_o, done_o);
        end
    endtask

    task automatic test_basic();
        int s;
        start_xfer(12'h010, 12'd4, s);
        // Start and input changes while busy must not disturb the transfer.
        start_i     = 1'b1;
        base_addr_i = 12'h700;
        num_rows_i  = 12'd9;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (ROWS + 6) @(negedge clk_i);
        checks++;
        if (ub_rd_addr_o !== 12'h013) begin errors++; $display("FAIL basic_addr_hold got=%h exp=013", ub_rd_addr_o); end
        finish_check("basic");
    endtask

    task automatic test_wrap();
        int s;
        start_xfer(12'hFFE, 12'd3, s);
        repeat (ROWS + 6) @(negedge clk_i);
        checks++;
        if (ub_rd_addr_o !== 12'h000) begin errors++; $display("FAIL wrap_addr_hold got=%h exp=000", ub_rd_addr_o); end
        finish_check("wrap");
    endtask

    task automatic test_zero_len();
        int s;
        start_xfer(12'h055, 12'd0, s);
        repeat (5) @(negedge clk_i);
        checks++;
        if (ub_rd_addr_o !== 12'h000) begin errors++; $display("FAIL zero_addr_hold got=%h exp=000", ub_rd_addr_o); end
        finish_check("zero_len");
    endtask

    task automatic test_back_to_back();
        int s, s2;
        start_xfer(12'h200, 12'd2, s);
        repeat (2 + ROWS + 1) @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle got=%b exp=1", done_o); end
        start_xfer(12'h300, 12'd1, s2);
        repeat (ROWS + 5) @(negedge clk_i);
        finish_check("back_to_back");
    endtask

    task automatic test_reset_mid();
        int s, s2;
        start_xfer(12'h040, 12'd8, s);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        rd_q.delete();
        lane_q.delete();
        busy_map.delete();
        done_map.delete();
        @(negedge clk_i);
        checks++;
        if (ub_rd_en_o !== 1'b0 || ub_rd_addr_o !== '0) begin
            errors++; $display("FAIL midrst_rd got en=%b addr=%h exp 0 000", ub_rd_en_o, ub_rd_addr_o);
        end
        checks++;
        if (mxu_valid_o !== '0 || mxu_data_o !== '0) begin
            errors++; $display("FAIL midrst_mxu got valid=%h exp 0 with zero data", mxu_valid_o);
        end
        rst_i = 1'b0;
        repeat (45) @(negedge clk_i);
        start_xfer(12'h080, 12'd1, s2);
        repeat (ROWS + 5) @(negedge clk_i);
        finish_check("reset_mid");
    endtask

    task automatic test_zero_pad();
        int s;
        logic [ROWS-1:0][DATA_W-1:0] exp_data;
        start_xfer(12'h123, 12'd2, s);
        repeat (ROWS + 6) @(negedge clk_i);
        for (int k = 0; k < ROWS; k++) begin
`ifdef FEEDER_ZERO_PAD_EN
            exp_data[k] = '0;
`else
            exp_data[k] = row_val(12'h124, k);
`endif
        end
        checks++;
        if (mxu_valid_o !== '0) begin errors++; $display("FAIL pad_valid got=%h exp=0", mxu_valid_o); end
        checks++;
        if (mxu_data_o !== exp_data) begin
            errors++; $display("FAIL pad_data got lane0=%h lane31=%h exp lane0=%h lane31=%h",
                               mxu_data_o[0], mxu_data_o[ROWS-1], exp_data[0], exp_data[ROWS-1]);
        end
        finish_check("zero_pad");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_zero_pad();
        repeat (3) @(negedge clk_i);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
